// File: rtl/pipelined_barrel_shifter_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types and helpers for the pipelined barrel shifter.
//   shift_op_t : shift mode encoding carried alongside every word.
//   width_of() : word width W = 2**N for a shifter with N stages.
// Optional feature macro used elsewhere in the slice: BSHIFT_FLAGS_EN.
// -----------------------------------------------------------------------------
package shift_pkg;

  // SH_RSV is decoded exactly like SH_ROT everywhere; it is never an error.
  typedef enum logic [1:0] {
    SH_ROT = 2'b00,
    SH_LSH = 2'b01,
    SH_ASH = 2'b10,
    SH_RSV = 2'b11
  } shift_op_t;

  function automatic int width_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter_if
// Valid/ready stream bundle between a producer, the shifter and a consumer.
//   Parameter N : log2 of the word width (W = 2**N).
//   in_valid/in_ready   : operand handshake (producer -> shifter)
//   in_data, in_amt     : operand word and shift amount (0..W-1)
//   in_lr, in_op        : direction (1 = left) and mode (shift_op_t)
//   out_valid/out_ready : result handshake (shifter -> consumer)
//   out_data            : shifted word
//   out_carry, out_zero : last bit shifted out / result-is-zero
//                         (only when BSHIFT_FLAGS_EN is defined)
// Modports: slave = shifter side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface pipelined_barrel_shifter_if #(
  parameter int N = 3
);
  import shift_pkg::*;

  localparam int W = width_of(N);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [N-1:0]   in_amt;
  logic           in_lr;
  shift_op_t      in_op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
`ifdef BSHIFT_FLAGS_EN
  logic           out_carry;
  logic           out_zero;
`endif

  modport slave (
    input  in_valid, in_data, in_amt, in_lr, in_op, out_ready,
    output in_ready, out_valid, out_data
`ifdef BSHIFT_FLAGS_EN
    , output out_carry, out_zero
`endif
  );

  modport master (
    output in_valid, in_data, in_amt, in_lr, in_op, out_ready,
    input  in_ready, out_valid, out_data
`ifdef BSHIFT_FLAGS_EN
    , input out_carry, out_zero
`endif
  );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// -----------------------------------------------------------------------------
// barrel_stage
// One pipeline stage of the barrel shifter: shifts its word by 2**K when
// amt[K] is set (otherwise passes it through) and registers the result
// together with the word's side-band (valid, amt, lr, op).
// Optional feature macro: BSHIFT_FLAGS_EN adds the carry chain and a
// registered zero flag.
// Parameters:
//   N : log2 of word width, K : stage index (shift distance 2**K)
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_en            : global advance enable; 0 holds every register
//   i_vld..i_op     : word and side-band from the previous stage
//   i_carry         : carry so far (BSHIFT_FLAGS_EN)
//   o_vld..o_op     : registered word and side-band
//   o_carry, o_zero : registered carry / result-is-zero (BSHIFT_FLAGS_EN)
// -----------------------------------------------------------------------------
module barrel_stage
  import shift_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_en,
  input  logic                     i_vld,
  input  logic [width_of(N)-1:0]   i_data,
  input  logic [N-1:0]             i_amt,
  input  logic                     i_lr,
  input  shift_op_t                i_op,
`ifdef BSHIFT_FLAGS_EN
  input  logic                     i_carry,
  output logic                     o_carry,
  output logic                     o_zero,
`endif
  output logic                     o_vld,
  output logic [width_of(N)-1:0]   o_data,
  output logic [N-1:0]             o_amt,
  output logic                     o_lr,
  output shift_op_t                o_op
);

  localparam int W = width_of(N);
  localparam int S = 1 << K;

  // Left shifts: LSH and ASH both fill with zeros; ROT/RSV wrap around.
  function automatic logic [W-1:0] shift_left(input logic [W-1:0] d,
                                              input shift_op_t op);
    case (op)
      SH_LSH, SH_ASH: shift_left = {d[W-S-1:0], {S{1'b0}}};
      default:        shift_left = {d[W-S-1:0], d[W-1:W-S]};
    endcase
  endfunction

  // Right shifts. For ASH the current MSB is still the original sign bit,
  // because every earlier arithmetic stage refilled it with itself.
  function automatic logic [W-1:0] shift_right(input logic [W-1:0] d,
                                               input shift_op_t op);
    logic signed [W-1:0] sd;
    sd = d;
    case (op)
      SH_LSH:  shift_right = {{S{1'b0}}, d[W-1:S]};
      SH_ASH:  shift_right = sd >>> S;
      default: shift_right = {d[S-1:0], d[W-1:S]};
    endcase
  endfunction

  logic           w_active;
  logic [W-1:0]   w_data_nxt;

  logic           r_vld;
  logic [W-1:0]   r_data;
  logic [N-1:0]   r_amt;
  logic           r_lr;
  shift_op_t      r_op;

  assign w_active = i_amt[K];

  always_comb begin
    w_data_nxt = i_data;
    if (w_active) begin
      if (i_lr) w_data_nxt = shift_left(i_data, i_op);
      else      w_data_nxt = shift_right(i_data, i_op);
    end
  end

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_amt  <= '0;
      r_lr   <= 1'b0;
      r_op   <= SH_ROT;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_data <= w_data_nxt;
      r_amt  <= i_amt;
      r_lr   <= i_lr;
      r_op   <= i_op;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_amt  = r_amt;
  assign o_lr   = r_lr;
  assign o_op   = r_op;

`ifdef BSHIFT_FLAGS_EN
  // The last bit leaving the word is at the same position for every mode:
  // bit W-S going left, bit S-1 going right. The last active stage wins,
  // which yields in_data[amt-1] / in_data[W-amt] for shifts and
  // result[W-1] / result[0] for rotates.
  logic w_carry_nxt;
  logic r_carry;
  logic r_zero;

  always_comb begin
    w_carry_nxt = i_carry;
    if (w_active) w_carry_nxt = i_lr ? i_data[W-S] : i_data[S-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_en) begin
      r_carry <= w_carry_nxt;
      r_zero  <= (w_data_nxt == '0);
    end
  end

  assign o_carry = r_carry;
  assign o_zero  = r_zero;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Streaming barrel shifter for W = 2**N bit words: rotate, logical and
// arithmetic shifts in both directions, one power-of-two step per stage,
// N stages, valid/ready handshake with full backpressure.
// Optional feature macro: BSHIFT_FLAGS_EN (out_carry / out_zero).
// Parameters:
//   N : log2 of word width; also the pipeline depth
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; flushes every in-flight word
//   bus   : pipelined_barrel_shifter_if.slave (operand in, result out)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  pipelined_barrel_shifter_if.slave       bus
);

  localparam int W = width_of(N);

  // Index 0 is the input boundary, index k+1 is the output of stage k.
  logic           w_vld  [N+1];
  logic [W-1:0]   w_data [N+1];
  logic [N-1:0]   w_amt  [N+1];
  logic           w_lr   [N+1];
  shift_op_t      w_op   [N+1];
  logic           w_en;

  // The whole pipe advances together: it may move whenever the output slot
  // is empty or being drained. Bubbles travel as valid=0 entries.
  assign w_en         = !w_vld[N] || bus.out_ready;
  assign bus.in_ready = w_en;

  assign w_vld[0]  = bus.in_valid;
  assign w_data[0] = bus.in_data;
  assign w_amt[0]  = bus.in_amt;
  assign w_lr[0]   = bus.in_lr;
  assign w_op[0]   = bus.in_op;

`ifdef BSHIFT_FLAGS_EN
  logic w_carry [N+1];
  logic w_zero  [N];

  // No stage has shifted yet, so nothing has been carried out.
  assign w_carry[0] = 1'b0;
`endif

  for (genvar k = 0; k < N; k++) begin : g_stage
    barrel_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_vld   (w_vld[k]),
      .i_data  (w_data[k]),
      .i_amt   (w_amt[k]),
      .i_lr    (w_lr[k]),
      .i_op    (w_op[k]),
`ifdef BSHIFT_FLAGS_EN
      .i_carry (w_carry[k]),
      .o_carry (w_carry[k+1]),
      .o_zero  (w_zero[k]),
`endif
      .o_vld   (w_vld[k+1]),
      .o_data  (w_data[k+1]),
      .o_amt   (w_amt[k+1]),
      .o_lr    (w_lr[k+1]),
      .o_op    (w_op[k+1])
    );
  end

  assign bus.out_valid = w_vld[N];
  assign bus.out_data  = w_data[N];

`ifdef BSHIFT_FLAGS_EN
  assign bus.out_carry = w_carry[N];
  assign bus.out_zero  = w_zero[N-1];
`endif

  // Side-band of the final stage has no consumer.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_amt[N], w_lr[N], w_op[N]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
  import shift_pkg::*;

  localparam int N = 3;
  localparam int W = 1 << N;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.N(N)) bus ();

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data;
  logic [W-1:0] last_d;
  logic         last_c;
  logic         last_z;
  int           run_len = 0;
  int           max_run = 0;
  int           n_out = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the mode rules.
  function automatic exp_t model(input logic [W-1:0] d, input int amt,
                                 input logic lr, input logic [1:0] op);
    exp_t e;
    logic [W-1:0] ones;
    int a;
    logic is_shift;
    ones = '1;
    a = amt % W;
    is_shift = (op == 2'b01) || (op == 2'b10);
    if (a == 0) begin
      e.d = d;
      e.c = 1'b0;
    end else if (lr) begin
      if (is_shift) begin
        e.d = d << a;
        e.c = d[W-a];
      end else begin
        e.d = (d << a) | (d >> (W - a));
        e.c = e.d[0];
      end
    end else begin
      if (is_shift) begin
        e.d = d >> a;
        if (op == 2'b10 && d[W-1]) e.d = e.d | ~(ones >> a);
        e.c = d[a-1];
      end else begin
        e.d = (d >> a) | (d << (W - a));
        e.c = e.d[W-1];
      end
    end
    return e;
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later (what the next
  // rising edge will see), then score accept/output events.
  task automatic step(input logic v, input logic [W-1:0] d, input int a,
                      input logic lr, input logic [1:0] op, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amt    = a[N-1:0];
    bus.in_lr     = lr;
    bus.in_op     = shift_op_t'(op);
    bus.out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_data", {24'b0, bus.out_data}, {24'b0, stall_data});
    end
    if (bus.out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("data", {24'b0, bus.out_data}, {24'b0, e.d});
`ifdef BSHIFT_FLAGS_EN
        chk("carry", {31'b0, bus.out_carry}, {31'b0, e.c});
        chk("zero", {31'b0, bus.out_zero}, {31'b0, (e.d == '0)});
        last_c = bus.out_carry;
        last_z = bus.out_zero;
`endif
        last_d = bus.out_data;
        n_out++;
      end
    end
    if (bus.in_valid && bus.in_ready) q.push_back(model(d, a, lr, op));
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) step(1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
    chk("drained", q.size(), 32'd0);
  endtask

  task automatic tp(input string tag, input logic [W-1:0] d, input int a, input logic lr,
                    input logic [1:0] op, input logic [W-1:0] exp_d, input logic exp_c);
    step(1'b1, d, a, lr, op, 1'b1);
    drain();
    chk(tag, {24'b0, last_d}, {24'b0, exp_d});
`ifdef BSHIFT_FLAGS_EN
    chk({tag, "_c"}, {31'b0, last_c}, {31'b0, exp_c});
`else
    if (exp_c === 1'bx) $display("note: undefined carry for %s", tag);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    logic rv, rlr, rordy;
    logic [1:0] rop;
    logic [W-1:0] rd;
    int ra;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_lr     = 1'b0;
    bus.in_op     = SH_ROT;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
`ifdef BSHIFT_FLAGS_EN
    chk("rst_carry", {31'b0, bus.out_carry}, 32'd0);
    chk("rst_zero", {31'b0, bus.out_zero}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Mode vectors on 0x96
    tp("rot_r3", 8'h96, 3, 1'b0, 2'b00, 8'hD2, 1'b1);
    tp("rot_l3", 8'h96, 3, 1'b1, 2'b00, 8'hB4, 1'b0);
    tp("lsh_r3", 8'h96, 3, 1'b0, 2'b01, 8'h12, 1'b1);
    tp("ash_r3", 8'h96, 3, 1'b0, 2'b10, 8'hF2, 1'b1);
    tp("lsh_l3", 8'h96, 3, 1'b1, 2'b01, 8'hB0, 1'b0);
    tp("ash_l3", 8'h96, 3, 1'b1, 2'b10, 8'hB0, 1'b0);
    tp("rsv_l3", 8'h96, 3, 1'b1, 2'b11, 8'hB4, 1'b0);
    for (int op = 0; op < 4; op++) tp("amt0", 8'h96, 0, op[0], op[1:0], 8'h96, 1'b0);

    // Latency on an empty pipe
    step(1'b1, 8'h96, 0, 1'b0, 2'b01, 1'b1);
    lat = 0;
    do begin
      step(1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk("latency", lat, N);
    drain();

    // Back-to-back stream, ROT left amt 0..7
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h96, i, 1'b1, 2'b00, 1'b1);
    drain();
    chk("stream_run", max_run, 32'd8);

    // Backpressure: fill, stall 5 cycles, release
    n0 = n_out;
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), $urandom_range(0, W-1), 1'b0, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'($urandom), $urandom_range(0, W-1), 1'b1, 2'b01, 1'b0);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    drain();
    chk("bp_count", n_out - n0, 32'd3);

    // Asynchronous reset with words in flight
    step(1'b1, 8'h5A, 1, 1'b1, 2'b00, 1'b1);
    step(1'b1, 8'hA5, 2, 1'b0, 2'b00, 1'b1);
    step(1'b0, '0, 0, 1'b0, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, bus.out_valid}, 32'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
    chk("post_rst_outputs", n_out - n0, 32'd0);

    // Zero flag cases
    tp("zero_in", 8'h00, 1, 1'b1, 2'b01, 8'h00, 1'b0);
`ifdef BSHIFT_FLAGS_EN
    chk("zero_in_z", {31'b0, last_z}, 32'd1);
`endif
    tp("zero_out", 8'h80, 1, 1'b1, 2'b01, 8'h00, 1'b1);
`ifdef BSHIFT_FLAGS_EN
    chk("zero_out_z", {31'b0, last_z}, 32'd1);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rv    = ($urandom % 4) != 0;
      rd    = W'($urandom);
      ra    = $urandom_range(0, W-1);
      rlr   = ($urandom % 2) != 0;
      rop   = 2'($urandom % 4);
      rordy = ($urandom % 3) != 0;
      step(rv, rd, ra, rlr, rop, rordy);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
